// File: rtl/light_phase_monitor.sv
// Receive-side checker for the traffic-light LED interface.
// Measures each colour phase in ticks and flags illegal order or duration.
module light_phase_monitor #(
    parameter int CNT_W = 8,
    parameter int TOL   = 0,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [1:0]       led,
    input  logic [11:0]      exp_time,
    input  logic             check_en,
    input  logic             clr_err,
    output logic [CNT_W-1:0] phase_time,
    output logic [CNT_W-1:0] last_dur,
    output logic             phase_done,
    output logic             seq_err,
    output logic             time_err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;
    localparam logic [1:0] OFF    = 2'b11;
    localparam int         SUM_W  = ERR_W + 1;
    localparam logic [CNT_W-1:0] TOL_C = CNT_W'(TOL);

    logic [1:0]       led_q;
    logic             valid;
    logic             change;
    logic             legal;
    logic             seq_hit;
    logic             time_hit;
    logic [CNT_W-1:0] expected;
    logic [CNT_W-1:0] diff;
    logic [1:0]       inc;
    logic [SUM_W-1:0] err_sum;

    always_comb begin
        change = (led != led_q);
        legal  = (led == OFF) || (led_q == OFF)
              || (led_q == GREEN  && led == YELLOW)
              || (led_q == YELLOW && led == RED)
              || (led_q == RED    && led == GREEN);
        expected = '0;
        case (led_q)
            RED:     expected = CNT_W'(exp_time[11:8]);
            GREEN:   expected = CNT_W'(exp_time[7:4]);
            YELLOW:  expected = CNT_W'(exp_time[3:0]);
            default: expected = '0;
        endcase
        diff = (phase_time >= expected) ? phase_time - expected
                                        : expected - phase_time;
        seq_hit  = change && check_en && !legal;
        // The ending phase is only judged when it was entered from a colour.
        time_hit = change && check_en && valid && (led_q != OFF)
                && (diff > TOL_C);
        inc     = {1'b0, seq_hit} + {1'b0, time_hit};
        err_sum = {1'b0, err_cnt} + SUM_W'(inc);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q      <= OFF;
            valid      <= 1'b0;
            phase_time <= '0;
            last_dur   <= '0;
            phase_done <= 1'b0;
            seq_err    <= 1'b0;
            time_err   <= 1'b0;
            err_cnt    <= '0;
        end else begin
            phase_done <= change;
            seq_err    <= seq_hit;
            time_err   <= time_hit;
            if (change) begin
                led_q      <= led;
                last_dur   <= phase_time;
                phase_time <= CNT_W'(tick);
                valid      <= (led != OFF) && (led_q != OFF);
            end else if (tick && (phase_time != '1)) begin
                phase_time <= phase_time + 1'b1;
            end
            if (clr_err)
                err_cnt <= '0;
            else if (err_sum[ERR_W])
                err_cnt <= '1;
            else
                err_cnt <= err_sum[ERR_W-1:0];
        end
    end

endmodule

// File: tb/tb_light_phase_monitor.sv
// Directed vector bench for light_phase_monitor (TOL=0 and TOL=2 copies).
module tb_light_phase_monitor;

    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] G = 2'b10;
    localparam logic [1:0] O = 2'b11;

    typedef struct {
        logic [1:0] led;
        logic       tick;
        logic       ce;
        logic       clr;
        logic [7:0] pt;
        logic [7:0] ld;
        logic       pd;
        logic       se;
        logic       te;
        logic [7:0] ec;
        logic       te2;
        logic [7:0] ec2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic [1:0]  led = O;
    logic [11:0] exp_time = 12'h532;
    logic        check_en = 1'b1;
    logic        clr_err = 1'b0;

    logic [7:0] pt0, ld0, ec0, pt2, ld2, ec2;
    logic       pd0, se0, te0, pd2, se2, te2;

    int n_vec = 0;
    int n_bad = 0;
    vec_t q[$];

    light_phase_monitor #(.CNT_W(8), .TOL(0), .ERR_W(8)) u0 (
        .clk(clk), .rst(rst), .tick(tick), .led(led),
        .exp_time(exp_time), .check_en(check_en), .clr_err(clr_err),
        .phase_time(pt0), .last_dur(ld0), .phase_done(pd0),
        .seq_err(se0), .time_err(te0), .err_cnt(ec0)
    );

    light_phase_monitor #(.CNT_W(8), .TOL(2), .ERR_W(8)) u2 (
        .clk(clk), .rst(rst), .tick(tick), .led(led),
        .exp_time(exp_time), .check_en(check_en), .clr_err(clr_err),
        .phase_time(pt2), .last_dur(ld2), .phase_done(pd2),
        .seq_err(se2), .time_err(te2), .err_cnt(ec2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] pt,
                       input logic [7:0] ld, input logic pd,
                       input logic se, input logic te,
                       input logic [7:0] ec, input logic t2,
                       input logic [7:0] e2);
        n_vec++;
        if (pt0 !== pt || ld0 !== ld || pd0 !== pd || se0 !== se ||
            te0 !== te || ec0 !== ec || te2 !== t2 || ec2 !== e2 ||
            pt2 !== pt || ld2 !== ld || pd2 !== pd || se2 !== se) begin
            n_bad++;
            $display("FAIL %s: got pt=%0d ld=%0d pd=%0b se=%0b te=%0b ec=%0d te2=%0b ec2=%0d, want pt=%0d ld=%0d pd=%0b se=%0b te=%0b ec=%0d te2=%0b ec2=%0d",
                     nm, pt0, ld0, pd0, se0, te0, ec0, te2, ec2,
                     pt, ld, pd, se, te, ec, t2, e2);
        end
    endtask

    task automatic step(input logic [1:0] l, input logic t);
        led  = l;
        tick = t;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [1:0] l, input logic t,
                                input logic ce, input logic cl,
                                input logic [7:0] pt, input logic [7:0] ld,
                                input logic pd, input logic se,
                                input logic te, input logic [7:0] ec,
                                input logic t2, input logic [7:0] e2);
        vec_t v;
        v.led = l; v.tick = t; v.ce = ce; v.clr = cl;
        v.pt = pt; v.ld = ld; v.pd = pd; v.se = se; v.te = te;
        v.ec = ec; v.te2 = t2; v.ec2 = e2;
        q.push_back(v);
    endfunction

    initial begin
        logic [1:0] ill [3];
        ill[0] = Y; ill[1] = G; ill[2] = R;

        // legal cycle, first GREEN after OFF unchecked
        add(G, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 3; k++) add(G, 1, 1, 0, 8'(k), 0, 0, 0, 0, 0, 0, 0);
        add(Y, 0, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 2; k++) add(Y, 1, 1, 0, 8'(k), 3, 0, 0, 0, 0, 0, 0);
        add(R, 0, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) add(R, 1, 1, 0, 8'(k), 2, 0, 0, 0, 0, 0, 0);
        add(G, 0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        add(G, 0, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0);
        // YELLOW held 4 ticks: error with TOL=0 only
        for (int k = 1; k <= 3; k++) add(G, 1, 1, 0, 8'(k), 5, 0, 0, 0, 0, 0, 0);
        add(Y, 0, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) add(Y, 1, 1, 0, 8'(k), 3, 0, 0, 0, 0, 0, 0);
        add(R, 0, 1, 0, 0, 4, 1, 0, 1, 1, 0, 0);
        add(R, 0, 1, 0, 0, 4, 0, 0, 0, 1, 0, 0);
        // GREEN->RED with and without checking
        for (int k = 1; k <= 5; k++) add(R, 1, 1, 0, 8'(k), 4, 0, 0, 0, 1, 0, 0);
        add(G, 0, 1, 0, 0, 5, 1, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 3; k++) add(G, 1, 1, 0, 8'(k), 5, 0, 0, 0, 1, 0, 0);
        add(R, 0, 1, 0, 0, 3, 1, 1, 0, 2, 0, 1);
        for (int k = 1; k <= 5; k++) add(R, 1, 1, 0, 8'(k), 3, 0, 0, 0, 2, 0, 1);
        add(G, 0, 1, 0, 0, 5, 1, 0, 0, 2, 0, 1);
        for (int k = 1; k <= 3; k++) add(G, 1, 1, 0, 8'(k), 5, 0, 0, 0, 2, 0, 1);
        add(R, 0, 0, 0, 0, 3, 1, 0, 0, 2, 0, 1);
        // tick coincident with the change edge
        for (int k = 1; k <= 4; k++) add(R, 1, 1, 0, 8'(k), 3, 0, 0, 0, 2, 0, 1);
        add(G, 1, 0, 0, 1, 4, 1, 0, 0, 2, 0, 1);

        #2 rst = 1'b0;
        #1 chk("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < q.size(); i++) begin
            check_en = q[i].ce;
            clr_err  = q[i].clr;
            step(q[i].led, q[i].tick);
            chk($sformatf("vec%0d", i), q[i].pt, q[i].ld, q[i].pd,
                q[i].se, q[i].te, q[i].ec, q[i].te2, q[i].ec2);
        end

        // saturation of phase_time
        check_en = 1'b1;
        for (int k = 0; k < 299; k++) step(G, 1);
        chk("pt_sat", 255, 4, 0, 0, 0, 2, 0, 1);

        // illegal and mistimed together
        step(R, 0);
        chk("both_err", 0, 255, 1, 1, 1, 4, 1, 3);

        exp_time = 12'h000;
        for (int k = 0; k < 250; k++) step(ill[k % 3], 0);
        chk("ec_254", 0, 0, 1, 1, 0, 254, 0, 253);
        exp_time = 12'hFFF;
        step(G, 0);
        chk("ec_sat", 0, 0, 1, 1, 1, 255, 1, 255);
        clr_err = 1'b1;
        step(R, 0);
        chk("ec_clr", 0, 0, 1, 1, 1, 0, 1, 0);
        clr_err = 1'b0;

        // asynchronous reset mid-phase
        exp_time = 12'h532;
        for (int k = 0; k < 3; k++) step(R, 1);
        chk("pre_rst", 3, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        #1 chk("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        step(R, 0);
        rst = 1'b1;
        step(R, 0);
        chk("from_off", 0, 0, 1, 0, 0, 0, 0, 0);
        step(R, 1);
        step(R, 1);
        step(G, 0);
        chk("unchecked", 0, 2, 1, 0, 0, 0, 0, 0);
        step(G, 1);
        step(Y, 0);
        chk("rechecked", 0, 1, 1, 0, 1, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
